traffic_signal_monitor: RTL and testbench

Receiving end of the traffic-controller signal interface. Consumes the 2-bit highway and farm-road signal codes (00 red, 01 green, 10 yellow) driven by the traffic light controller and decodes them to one-hot lamp drives. Checks the stream for protocol violations and, on the first violation, latches a fault and forces both roads to flashing red until software clears it.

---
 rtl/traffic_signal_monitor.sv | 189 ++++++++++++++++++
 tb/tb_traffic_signal_monitor.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_signal_monitor.sv
// Receive-side monitor for the traffic-controller signal codes: decodes them to
// one-hot lamps and latches the first protocol violation into a flashing-red fault.
module traffic_signal_monitor #(
    parameter int FLASH_HALF = 4,
    parameter int MIN_YELLOW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] highway_sig,
    input  logic [1:0] farm_sig,
    input  logic       fault_clear,
    output logic [2:0] hw_lamp,
    output logic [2:0] farm_lamp,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] change_count
);

    localparam logic [1:0] SIG_RED    = 2'b00;
    localparam logic [1:0] SIG_GREEN  = 2'b01;
    localparam logic [1:0] SIG_YELLOW = 2'b10;
    localparam logic [1:0] SIG_BAD    = 2'b11;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_YELLOW = 3'b010;
    localparam logic [2:0] LAMP_GREEN  = 3'b001;
    localparam logic [2:0] LAMP_DARK   = 3'b000;

    localparam logic [2:0] CODE_NONE     = 3'b000;
    localparam logic [2:0] CODE_BAD      = 3'b001;
    localparam logic [2:0] CODE_CONFLICT = 3'b010;
    localparam logic [2:0] CODE_TRANS    = 3'b011;
    localparam logic [2:0] CODE_SHORT_Y  = 3'b100;

    localparam int FLASH_PERIOD = 2 * FLASH_HALF;
    localparam int FW = (FLASH_PERIOD > 2) ? $clog2(FLASH_PERIOD) : 1;
    localparam logic [FW-1:0] FLASH_LAST   = FW'(FLASH_PERIOD - 1);
    localparam logic [FW-1:0] FLASH_HALF_W = FW'(FLASH_HALF);
    localparam logic [7:0]    MIN_Y        = 8'(MIN_YELLOW);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [1:0]    hw_cur_p0, farm_cur_p0;
    logic [1:0]    hw_prev_p1, farm_prev_p1;
    logic [7:0]    hw_ycnt, farm_ycnt;
    logic [FW-1:0] flash_cnt, flash_nxt;

    logic [2:0] hw_lamp_nxt, farm_lamp_nxt;
    logic       fault_nxt;
    logic [2:0] code_nxt;
    logic [7:0] count_nxt;

    logic       chk_bad, chk_conflict, chk_trans, chk_short;
    logic [2:0] code_init, code_run, code_sel;

    function automatic logic [2:0] decode_lamp(input logic [1:0] code);
        case (code)
            SIG_RED:    decode_lamp = LAMP_RED;
            SIG_GREEN:  decode_lamp = LAMP_GREEN;
            SIG_YELLOW: decode_lamp = LAMP_YELLOW;
            default:    decode_lamp = LAMP_DARK;
        endcase
    endfunction

    // Only the forward cycle R->G->Y->R (or holding) is a legal per-road change.
    function automatic logic legal_step(input logic [1:0] prev, input logic [1:0] cur);
        legal_step = (prev == cur)
                  || (prev == SIG_RED    && cur == SIG_GREEN)
                  || (prev == SIG_GREEN  && cur == SIG_YELLOW)
                  || (prev == SIG_YELLOW && cur == SIG_RED);
    endfunction

    function automatic logic short_yellow(input logic [1:0] prev, input logic [1:0] cur,
                                          input logic [7:0] ycnt);
        short_yellow = (prev == SIG_YELLOW) && (cur == SIG_RED) && (ycnt < MIN_Y);
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        sat_inc8 = (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    always_comb begin
        chk_bad      = (hw_cur_p0 == SIG_BAD) || (farm_cur_p0 == SIG_BAD);
        chk_conflict = (hw_cur_p0 != SIG_RED) && (farm_cur_p0 != SIG_RED);
        chk_trans    = !legal_step(hw_prev_p1, hw_cur_p0) || !legal_step(farm_prev_p1, farm_cur_p0);
        chk_short    = short_yellow(hw_prev_p1, hw_cur_p0, hw_ycnt)
                    || short_yellow(farm_prev_p1, farm_cur_p0, farm_ycnt);

        code_init = chk_bad      ? CODE_BAD      :
                    chk_conflict ? CODE_CONFLICT : CODE_NONE;
        code_run  = (code_init != CODE_NONE) ? code_init    :
                    chk_trans                ? CODE_TRANS   :
                    chk_short                ? CODE_SHORT_Y : CODE_NONE;
    end

    always_comb begin
        state_nxt     = state;
        flash_nxt     = flash_cnt;
        hw_lamp_nxt   = hw_lamp;
        farm_lamp_nxt = farm_lamp;
        fault_nxt     = fault;
        code_nxt      = fault_code;
        count_nxt     = change_count;
        code_sel      = CODE_NONE;

        unique case (state)
            ST_INIT, ST_RUN: begin
                // prev is untrusted in INIT, so only the single-sample checks apply there
                code_sel = (state == ST_RUN) ? code_run : code_init;
                if (code_sel != CODE_NONE) begin
                    state_nxt     = ST_FAULT;
                    fault_nxt     = 1'b1;
                    code_nxt      = code_sel;
                    flash_nxt     = '0;
                    hw_lamp_nxt   = LAMP_RED;
                    farm_lamp_nxt = LAMP_RED;
                end else begin
                    state_nxt     = ST_RUN;
                    hw_lamp_nxt   = decode_lamp(hw_cur_p0);
                    farm_lamp_nxt = decode_lamp(farm_cur_p0);
                    if (state == ST_RUN && hw_cur_p0 != hw_prev_p1)
                        count_nxt = change_count + 8'd1;
                end
            end
            ST_FAULT: begin
                if (fault_clear) begin
                    state_nxt     = ST_INIT;
                    fault_nxt     = 1'b0;
                    code_nxt      = CODE_NONE;
                    flash_nxt     = '0;
                    hw_lamp_nxt   = decode_lamp(hw_cur_p0);
                    farm_lamp_nxt = decode_lamp(farm_cur_p0);
                end else begin
                    flash_nxt     = (flash_cnt == FLASH_LAST) ? '0 : flash_cnt + FW'(1);
                    hw_lamp_nxt   = (flash_nxt < FLASH_HALF_W) ? LAMP_RED : LAMP_DARK;
                    farm_lamp_nxt = hw_lamp_nxt;
                end
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    // Stage p0/p1: sampled codes and their previous value; yellow run lengths track p0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hw_cur_p0    <= SIG_RED;
            farm_cur_p0  <= SIG_RED;
            hw_prev_p1   <= SIG_RED;
            farm_prev_p1 <= SIG_RED;
            hw_ycnt      <= 8'd0;
            farm_ycnt    <= 8'd0;
        end else begin
            hw_cur_p0    <= highway_sig;
            farm_cur_p0  <= farm_sig;
            hw_prev_p1   <= hw_cur_p0;
            farm_prev_p1 <= farm_cur_p0;
            hw_ycnt      <= (hw_cur_p0 == SIG_YELLOW) ? sat_inc8(hw_ycnt) : 8'd0;
            farm_ycnt    <= (farm_cur_p0 == SIG_YELLOW) ? sat_inc8(farm_ycnt) : 8'd0;
        end
    end

    // Output stage: state, flash phase and registered lamp/fault/count outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_INIT;
            flash_cnt    <= '0;
            hw_lamp      <= LAMP_RED;
            farm_lamp    <= LAMP_RED;
            fault        <= 1'b0;
            fault_code   <= CODE_NONE;
            change_count <= 8'd0;
        end else begin
            state        <= state_nxt;
            flash_cnt    <= flash_nxt;
            hw_lamp      <= hw_lamp_nxt;
            farm_lamp    <= farm_lamp_nxt;
            fault        <= fault_nxt;
            fault_code   <= code_nxt;
            change_count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_traffic_signal_monitor.sv
// Bench for traffic_signal_monitor: vector table, directed corner sequences and
// a randomized run, all against a history-based reference model.
module tb_traffic_signal_monitor;

    localparam int FLASH_HALF = 4;
    localparam int MIN_YELLOW = 2;

    localparam logic [1:0] R = 2'b00;
    localparam logic [1:0] G = 2'b01;
    localparam logic [1:0] Y = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] highway_sig, farm_sig;
    logic       fault_clear;
    logic [2:0] hw_lamp, farm_lamp;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] change_count;

    always #5 clk = ~clk;

    traffic_signal_monitor #(.FLASH_HALF(FLASH_HALF), .MIN_YELLOW(MIN_YELLOW)) dut (
        .clk(clk), .rst(rst), .highway_sig(highway_sig), .farm_sig(farm_sig),
        .fault_clear(fault_clear), .hw_lamp(hw_lamp), .farm_lamp(farm_lamp),
        .fault(fault), .fault_code(fault_code), .change_count(change_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: full sample history per road plus a mode and fault age.
    logic [1:0] mh[$];
    logic [1:0] mf[$];
    int         m_mode;   // 0 init, 1 run, 2 fault
    int         m_age;
    int         m_cnt;
    int         m_code;
    logic       m_fault;
    logic [2:0] m_hl, m_fl;
    bit         m_lamp_dc;

    typedef struct {
        logic [1:0] h;
        logic [1:0] f;
        logic [2:0] ehl;
        logic [2:0] efl;
        logic [7:0] ecnt;
    } vec_t;
    vec_t tbl[16];

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_tests++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [2:0] lamp_of(input logic [1:0] c);
        case (c)
            2'b00:   return 3'b100;
            2'b01:   return 3'b001;
            2'b10:   return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Position of a code in the R->G->Y cycle, -1 for the illegal code.
    function automatic int pos(input logic [1:0] c);
        return (c == 2'b11) ? -1 : int'(c);
    endfunction

    function automatic bit legal(input logic [1:0] p, input logic [1:0] c);
        if (p == c) return 1;
        if (pos(p) < 0 || pos(c) < 0) return 0;
        return pos(c) == (pos(p) + 1) % 3;
    endfunction

    // Consecutive yellow samples ending at the previous sample.
    function automatic int yrun(input bit farm);
        int n = 0;
        for (int i = mh.size() - 2; i >= 0; i--) begin
            if ((farm ? mf[i] : mh[i]) != Y) break;
            n++;
        end
        return (n > 255) ? 255 : n;
    endfunction

    function automatic void model_reset();
        mh.delete();
        mf.delete();
        mh.push_back(R); mh.push_back(R);
        mf.push_back(R); mf.push_back(R);
        m_mode = 0; m_age = 0; m_cnt = 0; m_code = 0;
        m_fault = 0; m_hl = 3'b100; m_fl = 3'b100; m_lamp_dc = 0;
    endfunction

    function automatic void model_edge(input logic [1:0] h, input logic [1:0] f, input logic c);
        int n;
        int code;
        logic [1:0] ch, ph, cf, pf;
        n = mh.size();
        ch = mh[n-1]; ph = mh[n-2];
        cf = mf[n-1]; pf = mf[n-2];
        code = 0;
        m_lamp_dc = 0;
        if (m_mode == 2) begin
            if (c) begin
                m_mode = 0; m_fault = 0; m_code = 0; m_lamp_dc = 1;
            end else begin
                m_age++;
                m_hl = (((m_age / FLASH_HALF) % 2) == 0) ? 3'b100 : 3'b000;
                m_fl = m_hl;
            end
        end else begin
            if (ch == X || cf == X) code = 1;
            else if (ch != R && cf != R) code = 2;
            else if (m_mode == 1) begin
                if (!legal(ph, ch) || !legal(pf, cf)) code = 3;
                else if ((ph == Y && ch == R && yrun(0) < MIN_YELLOW) ||
                         (pf == Y && cf == R && yrun(1) < MIN_YELLOW)) code = 4;
            end
            if (code != 0) begin
                m_mode = 2; m_age = 0; m_fault = 1; m_code = code;
                m_hl = 3'b100; m_fl = 3'b100;
            end else begin
                if (m_mode == 1 && ch != ph) m_cnt = (m_cnt + 1) % 256;
                m_mode = 1;
                m_hl = lamp_of(ch);
                m_fl = lamp_of(cf);
            end
        end
        mh.push_back(h);
        mf.push_back(f);
        if (mh.size() > 300) begin
            void'(mh.pop_front());
            void'(mf.pop_front());
        end
    endfunction

    task automatic compare_model();
        if (!m_lamp_dc) begin
            check("model_hw_lamp", hw_lamp, m_hl);
            check("model_farm_lamp", farm_lamp, m_fl);
        end
        check("model_fault", fault, m_fault);
        check("model_fault_code", fault_code, m_code);
        check("model_change_count", change_count, m_cnt);
    endtask

    // Called at a falling edge; applies one sample and checks at the next falling edge.
    task automatic step(input logic [1:0] h, input logic [1:0] f, input logic c);
        highway_sig = h;
        farm_sig    = f;
        fault_clear = c;
        @(posedge clk);
        model_edge(h, f, c);
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        highway_sig = R; farm_sig = R; fault_clear = 1'b0;
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int base;
        int p;
        int dwell;
        logic [1:0] h, f;
        logic c;

        rst = 1'b1; highway_sig = R; farm_sig = R; fault_clear = 1'b0;
        model_reset();

        // Legal sequence; outputs lag the applied sample by one row.
        tbl[0]  = '{G, R, 3'b100, 3'b100, 8'd0};
        tbl[1]  = '{G, R, 3'b001, 3'b100, 8'd1};
        tbl[2]  = '{G, R, 3'b001, 3'b100, 8'd1};
        tbl[3]  = '{G, R, 3'b001, 3'b100, 8'd1};
        tbl[4]  = '{G, R, 3'b001, 3'b100, 8'd1};
        tbl[5]  = '{Y, R, 3'b001, 3'b100, 8'd1};
        tbl[6]  = '{Y, R, 3'b010, 3'b100, 8'd2};
        tbl[7]  = '{R, G, 3'b010, 3'b100, 8'd2};
        tbl[8]  = '{R, G, 3'b100, 3'b001, 8'd3};
        tbl[9]  = '{R, G, 3'b100, 3'b001, 8'd3};
        tbl[10] = '{R, G, 3'b100, 3'b001, 8'd3};
        tbl[11] = '{R, Y, 3'b100, 3'b001, 8'd3};
        tbl[12] = '{R, Y, 3'b100, 3'b010, 8'd3};
        tbl[13] = '{G, R, 3'b100, 3'b010, 8'd3};
        tbl[14] = '{G, R, 3'b001, 3'b100, 8'd4};
        tbl[15] = '{G, R, 3'b001, 3'b100, 8'd4};

        @(negedge clk);
        check("reset_hw_lamp", hw_lamp, 3'b100);
        check("reset_farm_lamp", farm_lamp, 3'b100);
        check("reset_fault", fault, 1'b0);
        check("reset_fault_code", fault_code, 3'b000);
        check("reset_change_count", change_count, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].h, tbl[i].f, 1'b0);
            check($sformatf("vec%0d_hw_lamp", i), hw_lamp, tbl[i].ehl);
            check($sformatf("vec%0d_farm_lamp", i), farm_lamp, tbl[i].efl);
            check($sformatf("vec%0d_count", i), change_count, tbl[i].ecnt);
            check($sformatf("vec%0d_fault", i), fault, 1'b0);
        end

        // Conflict, then flashing with inputs ignored.
        step(G, G, 1'b0);
        step(G, R, 1'b0);
        check("conflict_fault", fault, 1'b1);
        check("conflict_code", fault_code, 3'b010);
        check("conflict_lamp", hw_lamp, 3'b100);
        for (int k = 1; k < 12; k++) begin
            step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0);
            check($sformatf("flash%0d_hw", k), hw_lamp, ((k % 8) < 4) ? 3'b100 : 3'b000);
            check($sformatf("flash%0d_farm", k), farm_lamp, ((k % 8) < 4) ? 3'b100 : 3'b000);
        end
        check("flash_count_held", change_count, 8'd4);
        check("flash_code_held", fault_code, 3'b010);

        step(R, R, 1'b1);
        step(R, R, 1'b0);
        check("clear_fault", fault, 1'b0);
        check("clear_code", fault_code, 3'b000);

        // Illegal code beats conflict.
        step(X, G, 1'b0);
        step(R, R, 1'b0);
        check("prio_code", fault_code, 3'b001);
        step(R, R, 1'b1);
        step(R, R, 1'b0);

        // Yellow held one sample is too short.
        step(G, R, 1'b0);
        step(Y, R, 1'b0);
        step(R, R, 1'b0);
        step(R, R, 1'b0);
        check("short_yellow_code", fault_code, 3'b100);
        step(R, R, 1'b1);
        step(R, R, 1'b0);

        // Yellow held two samples is fine.
        base = m_cnt;
        step(G, R, 1'b0);
        step(Y, R, 1'b0);
        step(Y, R, 1'b0);
        step(R, R, 1'b0);
        step(R, R, 1'b0);
        step(R, R, 1'b0);
        check("long_yellow_fault", fault, 1'b0);
        check("long_yellow_count", change_count, 8'((base + 3) % 256));

        // Skipping yellow, then clear while highway shows yellow.
        step(G, R, 1'b0);
        step(R, R, 1'b0);
        step(R, R, 1'b0);
        check("skip_yellow_code", fault_code, 3'b011);
        step(Y, R, 1'b1);
        step(Y, R, 1'b0);
        check("reinit_fault", fault, 1'b0);
        check("reinit_hw_lamp", hw_lamp, 3'b010);
        step(Y, R, 1'b0);
        check("rerun_fault", fault, 1'b0);

        // Seven changes, fault, then asynchronous reset in the flash-off phase.
        do_reset();
        begin
            logic [1:0] hs[12];
            hs = '{G, G, Y, Y, R, G, G, Y, Y, R, G, G};
            for (int i = 0; i < 12; i++) step(hs[i], R, 1'b0);
        end
        step(G, G, 1'b0);
        step(G, R, 1'b0);
        check("pre_reset_count", change_count, 8'd7);
        check("pre_reset_fault", fault, 1'b1);
        for (int k = 1; k <= 4; k++) step(R, R, 1'b0);
        check("flash_off_lamp", hw_lamp, 3'b000);
        #2 rst = 1'b1;
        #1;
        check("async_hw_lamp", hw_lamp, 3'b100);
        check("async_farm_lamp", farm_lamp, 3'b100);
        check("async_fault", fault, 1'b0);
        check("async_code", fault_code, 3'b000);
        check("async_count", change_count, 8'd0);
        model_reset();
        highway_sig = R; farm_sig = R; fault_clear = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step(G, R, 1'b0);
        step(G, R, 1'b0);
        check("post_reset_hw_lamp", hw_lamp, 3'b001);
        check("post_reset_fault", fault, 1'b0);
        check("post_reset_count", change_count, 8'd1);

        // Randomized: mostly-legal phase walk with occasional corruption and clears.
        do_reset();
        p = 0;
        dwell = 3;
        for (int i = 0; i < 2000; i++) begin
            case (p)
                0:       begin h = G; f = R; end
                1:       begin h = Y; f = R; end
                2:       begin h = R; f = G; end
                default: begin h = R; f = Y; end
            endcase
            if ($urandom_range(0, 39) == 0) h = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) f = 2'($urandom_range(0, 3));
            c = m_fault ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 19) == 0);
            step(h, f, c);
            dwell--;
            if (dwell == 0) begin
                p = (p + 1) % 4;
                dwell = $urandom_range(1, 4);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
